data_mem_arbiter: RTL
=====================

# data_mem_arbiter

- Two-requester arbiter and sequencer for the 8-bit processor's single-port data memory (32 × 8, combinational read, posedge-clock write).
- Shares the memory between the CPU datapath (port 0) and a loader/DMA/debug agent (port 1) using per-port req/gnt handshakes and round-robin fairness.
- Drives the memory's address, write-data, write-enable and read-enable signals and returns registered read data with a valid pulse.
- Rejects addresses at or beyond the memory depth.

## Interface
- ADDR_W, 8, address width, matching the memory address bus
- DATA_W, 8, data width
- MEM_DEPTH, 32, number of implemented words; addresses ≥ MEM_DEPTH are out of range
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- reqN  in  1  port N (N = 0, 1) request; held with its command until gntN
- weN  in  1  port N: 1 = write, 0 = read; stable while reqN is high
- addrN  in  ADDR_W  port N address; stable while reqN is high
- wdataN  in  DATA_W  port N write data; stable while reqN is high
- gntN  out  1  one-cycle pulse: port N's command is executing this cycle
- rvalidN  out  1  one-cycle pulse: rdataN is valid (reads only)
- rdataN  out  DATA_W  registered read data for port N
- errN  out  1  one-cycle pulse with gntN when addrN ≥ MEM_DEPTH
- mem_address  out  ADDR_W  to the memory's address input
- mem_writeData  out  DATA_W  to the memory's write-data input
- mem_MemWrite  out  1  to the memory's write enable
- mem_MemRead  out  1  to the memory's read enable
- mem_readData  in  DATA_W  from the memory's read-data output

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any req is high, register the winner index and its command, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Drive the memory from the latched command and pulse gnt of the winner.
  - Always return to IDLE. Peak throughput is one access per 2 cycles.
- Arbitration:
  - Round-robin; the `last` register holds the most recently granted port.
  - If both ports request, the port ≠ last wins. If one port requests, it wins.
  - `last` resets to 1, so port 0 wins the first tie.
  - `last` updates on the IDLE→ACCESS edge.
- Write in ACCESS, in range:
  - mem_MemWrite = 1, mem_MemRead = 0, mem_writeData = latched wdata.
  - The memory commits at the end of the ACCESS cycle. No rvalid pulse.
- Read in ACCESS, in range:
  - mem_MemRead = 1, mem_MemWrite = 0.
  - mem_readData is captured into rdataN at the end of ACCESS.
- Out-of-range access (addr ≥ MEM_DEPTH):
  - mem_MemWrite = 0 and mem_MemRead = 0; the memory is never written.
  - errN pulses with gntN.
  - A read returns rdataN = 0 with rvalidN as normal.
- Outside ACCESS: mem_MemWrite = 0, mem_MemRead = 0, mem_address = 0, mem_writeData = 0.
- The requester drops or renews reqN on the edge ending the gntN cycle. A req still high in the following IDLE cycle is a new request.
- The non-winning request stays pending. It is granted on the next IDLE cycle, so maximum wait is 2 cycles after the competing grant.
- rdataN holds its value until that port's next read completes.

## Timing
- Request first seen high in IDLE at cycle T:
  - gnt and memory strobes at T+1.
  - Write visible in memory from T+2.
  - rvalid and rdata at T+2.
- Read latency: 2 cycles from the req-sampled edge to rvalid.
- Reset:
  - State → IDLE, last → 1.
  - gnt0/1, rvalid0/1, err0/1 → 0; rdata0/1 → 0; all mem_* outputs → 0.
- Reset high during ACCESS:
  - mem_MemWrite, mem_MemRead and gnt are gated low combinationally; no write commits.
  - No rvalid follows. The requester retries after reset.
- Simultaneous requests: resolved per round-robin. Two requesters alternate strictly, giving each one access per 4 cycles.

## Structure
- Package data_mem_arb_pkg:
  - State enum {IDLE, ACCESS}.
  - Port index constants PORT_CPU = 0, PORT_AUX = 1.
  - Default width/depth constants.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from (req0, req1, last) → winner index and any-request flag.
- Top level: FSM, command latch, output muxing, rdata/rvalid/err registers.

## Test plan
- Single read: after reset, port 0 reads addr 3 (memory preloaded with 3) → gnt0 at T+1, rvalid0 with rdata0 = 0x03 at T+2; port 1 outputs stay 0.
- Write then read: port 1 writes 0xA5 to addr 17, then reads addr 17 → mem_MemWrite high only in the gnt1 cycle; read returns 0xA5.
- Contention: req0 and req1 held high continuously → grants alternate 0, 1, 0, 1 at cycles T+1, T+3, T+5, T+7; no grant ever adjacent to another.
- Out of range:
  - Port 0 writes 0x55 to addr 40 → err0 with gnt0, mem_MemWrite = 0.
  - A following read of addr 40 → rvalid0 with rdata0 = 0x00 and err0.
- Reset mid-access: assert reset during the ACCESS cycle of a port 1 write of 0x77 to addr 5 → no gnt1, no write; a later read of addr 5 returns 0x05.
- Idle behaviour: no requests for 10 cycles → all mem_* outputs 0, no gnt/rvalid/err pulses.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_DEPTH = 32;

  // Port indices; the winner index is a single bit.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// granted last wins, otherwise the lone requester wins.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lastPort,
  output logic winner,
  output logic anyReq
);

  // Pick the winner index from the current requests and the last grant.
  always_comb begin
    anyReq = req0 | req1;
    winner = PORT_CPU;
    if (req0 && req1) begin
      winner = ~lastPort;
    end else if (req1) begin
      winner = PORT_AUX;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 single-port data memory.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// them stable until it sees gntN. gntN is a one-cycle pulse marking the cycle
// the command drives the memory; the requester drops or renews reqN on the
// edge that ends that cycle. A read completes with a one-cycle rvalidN pulse
// on the following cycle, rdataN holding the data until the next read of that
// port. errN pulses together with gntN when addrN is beyond the memory depth.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_readData,
  output state_t            dbgState
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              state;
  state_t              nextState;
  logic                lastPort;
  logic                winner;
  logic                anyReq;
  logic                curPort;
  logic                curWe;
  logic [ADDR_W-1:0]   curAddr;
  logic [DATA_W-1:0]   curWdata;
  logic                inAccess;
  logic                inRange;
  logic                readDone0;
  logic                readDone1;

  rr_arbiter2 u_rr (
    .req0     (req0),
    .req1     (req1),
    .lastPort (lastPort),
    .winner   (winner),
    .anyReq   (anyReq)
  );

  // Reset gates the access cycle combinationally so no strobe escapes.
  assign inAccess  = (state == ACCESS) && !reset;
  assign inRange   = ({1'b0, curAddr} < DEPTH_L);
  assign readDone0 = inAccess && !curWe && (curPort == PORT_CPU);
  assign readDone1 = inAccess && !curWe && (curPort == PORT_AUX);
  assign dbgState  = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: any request starts an access, every access returns to IDLE.
  always_comb begin
    nextState = IDLE;
    if (state == IDLE && anyReq) begin
      nextState = ACCESS;
    end
  end

  // Latch the winner's command and remember who was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastPort <= PORT_AUX;
      curPort  <= PORT_CPU;
      curWe    <= 1'b0;
      curAddr  <= '0;
      curWdata <= '0;
    end else if (state == IDLE && anyReq) begin
      lastPort <= winner;
      curPort  <= winner;
      curWe    <= (winner == PORT_AUX) ? we1    : we0;
      curAddr  <= (winner == PORT_AUX) ? addr1  : addr0;
      curWdata <= (winner == PORT_AUX) ? wdata1 : wdata0;
    end
  end

  // Drive the memory and the grant/error pulses during the access cycle.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_MemWrite  = 1'b0;
    mem_MemRead   = 1'b0;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    err0          = 1'b0;
    err1          = 1'b0;
    if (inAccess) begin
      mem_address   = curAddr;
      mem_writeData = curWdata;
      mem_MemWrite  = curWe && inRange;
      mem_MemRead   = !curWe && inRange;
      gnt0          = (curPort == PORT_CPU);
      gnt1          = (curPort == PORT_AUX);
      err0          = (curPort == PORT_CPU) && !inRange;
      err1          = (curPort == PORT_AUX) && !inRange;
    end
  end

  // Capture read data at the end of the access; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= readDone0;
      rvalid1 <= readDone1;
      if (readDone0) begin
        rdata0 <= inRange ? mem_readData : '0;
      end
      if (readDone1) begin
        rdata1 <= inRange ? mem_readData : '0;
      end
    end
  end

endmodule
